// File: rtl/srm_pkg.sv
// Shared encodings for the srm instruction decoder and control FSM.
package srm_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {WAIT, DECODE, WIMM, GETA, GETB, ALU, CMP, WRD} state_t;

    typedef enum logic [2:0] {
        CLS_ILL, CLS_MOVI, CLS_MOVR, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN
    } cls_t;

endpackage

// File: rtl/srm_instr_dec.sv
// Splits the instruction register into fields, immediates and an instruction class.
module srm_instr_dec
    import srm_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output cls_t              cls
);

    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

    always_comb begin
        cls = CLS_ILL;
        case ({ir[15:13], ir[12:11]})
            {OPC_MOV, OP_MOVI}: cls = CLS_MOVI;
            {OPC_MOV, OP_MOVR}: cls = CLS_MOVR;
            {OPC_ALU, OP_ADD}:  cls = CLS_ADD;
            {OPC_ALU, OP_CMP}:  cls = CLS_CMP;
            {OPC_ALU, OP_AND}:  cls = CLS_AND;
            {OPC_ALU, OP_MVN}:  cls = CLS_MVN;
            default:            cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/srm_controller.sv
// Control FSM for the 16-bit datapath: latches one instruction and sequences its strobes.
module srm_controller
    import srm_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic [DATA_W-1:0] in,
    output logic              w,
    output logic              illegal,
    output logic [REG_AW-1:0] readnum,
    output logic [REG_AW-1:0] writenum,
    output logic              write,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [2:0]        rn, rd, rm;
    cls_t              cls;

    srm_instr_dec #(
        .DATA_W(DATA_W)
    ) u_dec (
        .ir    (ir),
        .rn    (rn),
        .rd    (rd),
        .rm    (rm),
        .shift (shift),
        .sximm8(sximm8),
        .sximm5(sximm5),
        .cls   (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            unique case (state)
                WAIT: begin
                    if (s) begin
                        ir    <= in;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    case (cls)
                        CLS_MOVI:                   state <= WIMM;
                        CLS_MOVR, CLS_MVN:          state <= GETB;
                        CLS_ADD, CLS_CMP, CLS_AND:  state <= GETA;
                        default:                    state <= WAIT;
                    endcase
                end
                WIMM: state <= WAIT;
                GETA: state <= GETB;
                GETB: state <= (cls == CLS_CMP) ? CMP : ALU;
                ALU:  state <= WRD;
                CMP:  state <= WAIT;
                WRD:  state <= WAIT;
            endcase
        end
    end

    // Moore decode: every strobe is a function of the state register and the latched IR.
    always_comb begin
        w        = (state == WAIT);
        illegal  = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = ALU_ADD;
        unique case (state)
            WAIT: ;
            DECODE: illegal = (cls == CLS_ILL);
            WIMM: begin
                writenum = REG_AW'(rn);
                vsel     = VSEL_IMM8;
                write    = 1'b1;
            end
            GETA: begin
                readnum = REG_AW'(rn);
                loada   = 1'b1;
            end
            GETB: begin
                readnum = REG_AW'(rm);
                loadb   = 1'b1;
            end
            ALU: begin
                loadc = 1'b1;
                asel  = (cls == CLS_MOVR) || (cls == CLS_MVN);
                case (cls)
                    CLS_AND: ALUop = ALU_AND;
                    CLS_MVN: ALUop = ALU_NOT;
                    default: ALUop = ALU_ADD;
                endcase
            end
            CMP: begin
                ALUop = ALU_SUB;
                loads = 1'b1;
            end
            WRD: begin
                writenum = REG_AW'(rd);
                vsel     = VSEL_C;
                write    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_srm_controller.sv
// Scoreboard bench for srm_controller: stimulus queues per-cycle expectations, monitor checks them.
module tb_srm_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s;
    logic [15:0] in;
    logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    typedef struct packed {
        logic        w;
        logic        illegal;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } vec_t;

    vec_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          step = 0;
    string       cur_name = "reset";
    logic [1:0]  cur_sh = 2'b00;
    logic [15:0] cur_x8 = 16'h0000;
    logic [15:0] cur_x5 = 16'h0000;

    srm_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s       (s),
        .in      (in),
        .w       (w),
        .illegal (illegal),
        .readnum (readnum),
        .writenum(writenum),
        .write   (write),
        .vsel    (vsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .shift   (shift),
        .ALUop   (ALUop),
        .sximm8  (sximm8),
        .sximm5  (sximm5)
    );

    always #5 clk = ~clk;

    function automatic vec_t actual();
        vec_t v;
        v = '{w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
              asel, bsel, shift, ALUop, sximm8, sximm5};
        return v;
    endfunction

    // Monitor: one expected vector per falling edge while the scoreboard holds entries.
    initial begin
        vec_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual();
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s step %0d: got %h expected %h", cur_name, step, a, e);
                end
                step++;
            end
        end
    end

    // Args: w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc, loads, ALUop, asel
    task automatic ex(input logic ew, input logic eill, input logic [2:0] ern,
                      input logic [2:0] ewn, input logic ewr, input logic [1:0] evs,
                      input logic ela, input logic elb, input logic elc, input logic els,
                      input logic [1:0] eop, input logic eas);
        vec_t v;
        v = '{ew, eill, ern, ewn, ewr, evs, ela, elb, elc, els, eas, 1'b0,
              cur_sh, eop, cur_x8, cur_x5};
        exp_q.push_back(v);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d pending expected 0", cur_name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at negedge+1 with the DUT in WAIT; drives s and records the IR-derived fields.
    task automatic start(input string nm, input logic [15:0] instr, input logic [1:0] sh,
                         input logic [15:0] x8, input logic [15:0] x5);
        cur_name = nm;
        step     = 0;
        cur_sh   = sh;
        cur_x8   = x8;
        cur_x5   = x5;
        s        = 1'b1;
        in       = instr;
    endtask

    task automatic finish_instr();
        @(posedge clk);
        #1;
        s = 1'b0;
        wait_empty();
    endtask

    task automatic e_dec();  ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0); endtask
    task automatic e_wait(); ex(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0); endtask

    initial begin
        rst_n = 1'b0;
        s     = 1'b0;
        in    = 16'h0000;
        e_wait();
        wait_empty();
        rst_n = 1'b1;

        start("mov_imm_r1", 16'hD134, 2'b10, 16'h0034, 16'hFFF4);
        e_dec(); ex(0, 0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0); e_wait();
        finish_instr();

        start("mov_imm_r2_neg", 16'hD2FF, 2'b11, 16'hFFFF, 16'hFFFF);
        e_dec(); ex(0, 0, 0, 2, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0); e_wait();
        finish_instr();

        start("add_r3", 16'hA16A, 2'b01, 16'h006A, 16'h000A);
        e_dec();
        ex(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0);
        ex(0, 0, 2, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0);
        ex(0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        e_wait();
        finish_instr();

        start("cmp_r1_r2", 16'hA902, 2'b00, 16'h0002, 16'h0002);
        e_dec();
        ex(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0);
        ex(0, 0, 2, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b01, 0);
        e_wait();
        finish_instr();

        start("mvn_r4", 16'hB882, 2'b00, 16'hFF82, 16'h0002);
        e_dec();
        ex(0, 0, 2, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b11, 1);
        ex(0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        e_wait();
        finish_instr();

        start("and_r7", 16'hB4E3, 2'b00, 16'hFFE3, 16'h0003);
        e_dec();
        ex(0, 0, 4, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0);
        ex(0, 0, 3, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b10, 0);
        ex(0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        e_wait();
        finish_instr();

        start("mov_reg_r5", 16'hC0A1, 2'b00, 16'hFFA1, 16'h0001);
        e_dec();
        ex(0, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 1);
        ex(0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        e_wait();
        finish_instr();

        start("illegal", 16'hE000, 2'b00, 16'h0000, 16'h0000);
        ex(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        e_wait();
        finish_instr();

        // s pulsed with a different word while busy must not disturb the running ADD.
        start("add_busy_s", 16'hA16A, 2'b01, 16'h006A, 16'h000A);
        e_dec();
        ex(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0);
        ex(0, 0, 2, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        ex(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0);
        ex(0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0);
        e_wait();
        @(posedge clk);
        #1;
        in = 16'hD7FF;
        @(posedge clk);
        @(posedge clk);
        #1;
        s = 1'b0;
        wait_empty();

        // Reset asserted while the ADD sits in GETB.
        start("add_reset", 16'hA16A, 2'b01, 16'h006A, 16'h000A);
        e_dec();
        ex(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0);
        ex(0, 0, 2, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0);
        finish_instr();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({w, write, loada, loadb, loadc, loads, readnum} !== {1'b1, 5'b00000, 3'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got w=%b wr=%b la=%b lb=%b lc=%b ls=%b rn=%0d expected w=1 rest 0",
                     w, write, loada, loadb, loadc, loads, readnum);
        end
        cur_name = "reset_hold";
        step     = 0;
        cur_sh   = 2'b00;
        cur_x8   = 16'h0000;
        cur_x5   = 16'h0000;
        e_wait();
        wait_empty();
        rst_n = 1'b1;

        start("mov_after_reset", 16'hD134, 2'b10, 16'h0034, 16'hFFF4);
        e_dec(); ex(0, 0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0); e_wait();
        finish_instr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
